elastic_pipe_stage: RTL and testbench

//   Parametrised pipeline register with a valid/ready handshake, stall and flush.
//   It carries one generic payload plus control flags between the IF/RF/EX/MEM/WB stages.
//   It replaces the fixed-field, always-enabled stage registers.
//   An optional 2-entry skid buffer makes in_ready a registered signal, so back-pressure

---
 rtl/elastic_pipe_stage.sv | 138 +++++++++++++
 tb/tb_elastic_pipe_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipe_stage.sv
// Pipeline register with valid/ready handshake, stall and flush.
// With SKID=1 a second entry absorbs one beat so in_ready_o is driven only by flops and reset.
module elastic_pipe_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int FLAG_COUNT = 10,
  parameter bit SKID       = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [FLAG_COUNT-1:0] in_flags_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [FLAG_COUNT-1:0] out_flags_o,
  output logic [1:0]            occupancy_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [FLAG_COUNT-1:0] main_flags_q, main_flags_d;
  logic [FLAG_COUNT-1:0] skid_flags_q, skid_flags_d;
  logic                  valid_q, valid_d;
  logic [1:0]            occ_q, occ_d;
  logic                  accept_s;
  logic                  emit_s;

  generate
    if (SKID) begin : g_skid_ready
      assign in_ready_o = (state_q != ST_SKID) & ~reset_i;
    end else begin : g_comb_ready
      assign in_ready_o = (~valid_q | out_ready_i) & ~reset_i;
    end
  endgenerate

  assign accept_s    = in_valid_i & in_ready_o;
  assign emit_s      = valid_q & out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = main_data_q;
  assign out_flags_o = main_flags_q;
  assign occupancy_o = occ_q;

  // Next-state logic; flags are zeroed whenever their entry leaves so bubbles carry no flags.
  always_comb begin
    state_d      = state_q;
    main_data_d  = main_data_q;
    main_flags_d = main_flags_q;
    skid_data_d  = skid_data_q;
    skid_flags_d = skid_flags_q;
    valid_d      = 1'b0;
    occ_d        = 2'd0;
    if (flush_i) begin
      state_d      = ST_EMPTY;
      main_flags_d = '0;
      skid_flags_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            state_d      = ST_FULL;
            main_data_d  = in_data_i;
            main_flags_d = in_flags_i;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (accept_s && emit_s) begin
            main_data_d  = in_data_i;
            main_flags_d = in_flags_i;
          end else if (accept_s && SKID) begin
            state_d      = ST_SKID;
            skid_data_d  = in_data_i;
            skid_flags_d = in_flags_i;
          end else if (emit_s) begin
            state_d      = ST_EMPTY;
            main_flags_d = '0;
          end else begin
            state_d = ST_FULL;
          end
        end
        ST_SKID: begin
          if (emit_s) begin
            state_d      = ST_FULL;
            main_data_d  = skid_data_q;
            main_flags_d = skid_flags_q;
            skid_flags_d = '0;
          end else begin
            state_d = ST_SKID;
          end
        end
        default: begin
          state_d      = ST_EMPTY;
          main_flags_d = '0;
          skid_flags_d = '0;
        end
      endcase
    end
    case (state_d)
      ST_EMPTY: begin valid_d = 1'b0; occ_d = 2'd0; end
      ST_FULL:  begin valid_d = 1'b1; occ_d = 2'd1; end
      ST_SKID:  begin valid_d = 1'b1; occ_d = 2'd2; end
      default:  begin valid_d = 1'b0; occ_d = 2'd0; end
    endcase
  end

  // State and entry registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_EMPTY;
      main_data_q  <= '0;
      main_flags_q <= '0;
      skid_data_q  <= '0;
      skid_flags_q <= '0;
      valid_q      <= 1'b0;
      occ_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      main_data_q  <= main_data_d;
      main_flags_q <= main_flags_d;
      skid_data_q  <= skid_data_d;
      skid_flags_q <= skid_flags_d;
      valid_q      <= valid_d;
      occ_q        <= occ_d;
    end
  end

endmodule

// File: tb/tb_elastic_pipe_stage.sv
// Self-checking bench for elastic_pipe_stage: one instance with SKID=1, one with SKID=0,
// directed scenarios followed by a randomised queue-based scoreboard run.
module tb_elastic_pipe_stage;
  localparam int DW = 64;
  localparam int FC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          flush1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [DW-1:0] in_data1, out_data1;
  logic [FC-1:0] in_flags1, out_flags1;
  logic [1:0]    occupancy1;
  logic          flush0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic [DW-1:0] in_data0, out_data0;
  logic [FC-1:0] in_flags0, out_flags0;
  logic [1:0]    occupancy0;

  elastic_pipe_stage #(.DATA_WIDTH(DW), .FLAG_COUNT(FC), .SKID(1'b1)) dut1 (
    .clk_i(clk), .reset_i(reset), .flush_i(flush1),
    .in_valid_i(in_valid1), .in_ready_o(in_ready1), .in_data_i(in_data1), .in_flags_i(in_flags1),
    .out_valid_o(out_valid1), .out_ready_i(out_ready1), .out_data_o(out_data1),
    .out_flags_o(out_flags1), .occupancy_o(occupancy1));

  elastic_pipe_stage #(.DATA_WIDTH(DW), .FLAG_COUNT(FC), .SKID(1'b0)) dut0 (
    .clk_i(clk), .reset_i(reset), .flush_i(flush0),
    .in_valid_i(in_valid0), .in_ready_o(in_ready0), .in_data_i(in_data0), .in_flags_i(in_flags0),
    .out_valid_o(out_valid0), .out_ready_i(out_ready0), .out_data_o(out_data0),
    .out_flags_o(out_flags0), .occupancy_o(occupancy0));

  int tests = 0;
  int fails = 0;
  logic [DW+FC-1:0] q1[$];
  logic [DW+FC-1:0] q0[$];

  // Values sampled just before each rising edge.
  logic          acc1, em1, v1, ir1, fl1, or1, acc0, em0, v0, ir0, fl0, or0;
  logic [DW-1:0] od1, id1, od0, id0;
  logic [FC-1:0] of1, if1, of0, if0;
  logic [1:0]    oc1, oc0;

  function automatic logic [FC-1:0] mkf(input logic [DW-1:0] d);
    return (d[FC-1:0] ^ 10'h2B7) | 10'h001;
  endfunction

  task automatic idle();
    flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1; in_data1 = '0; in_flags1 = '0;
    flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b1; in_data0 = '0; in_flags0 = '0;
  endtask

  task automatic advance();
    #1;
    acc1 = in_valid1 & in_ready1; em1 = out_valid1 & out_ready1; v1 = out_valid1; ir1 = in_ready1;
    fl1 = flush1; or1 = out_ready1; od1 = out_data1; of1 = out_flags1; oc1 = occupancy1;
    id1 = in_data1; if1 = in_flags1;
    acc0 = in_valid0 & in_ready0; em0 = out_valid0 & out_ready0; v0 = out_valid0; ir0 = in_ready0;
    fl0 = flush0; or0 = out_ready0; od0 = out_data0; of0 = out_flags0; oc0 = occupancy0;
    id0 = in_data0; if0 = in_flags0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    in_valid1 = 1'b1; in_data1 = 64'h55; in_flags1 = 10'h3FF;
    in_valid0 = 1'b1; in_data0 = 64'h66; in_flags0 = 10'h3FF;
    repeat (2) @(negedge clk);
    tests++; if (out_valid1 !== 1'b0) begin fails++; $display("FAIL reset_valid1 got=%b exp=0", out_valid1); end
    tests++; if (out_flags1 !== '0) begin fails++; $display("FAIL reset_flags1 got=%h exp=0", out_flags1); end
    tests++; if (in_ready1 !== 1'b0) begin fails++; $display("FAIL reset_ready1 got=%b exp=0", in_ready1); end
    tests++; if (occupancy1 !== 2'd0) begin fails++; $display("FAIL reset_occ1 got=%0d exp=0", occupancy1); end
    tests++; if (out_valid0 !== 1'b0 || out_flags0 !== '0 || in_ready0 !== 1'b0 || occupancy0 !== 2'd0) begin
      fails++; $display("FAIL reset_skid0 got v=%b f=%h r=%b o=%0d exp all 0", out_valid0, out_flags0, in_ready0, occupancy0);
    end
    reset = 1'b0;
    idle();
    #1;
    tests++; if (in_ready1 !== 1'b1) begin fails++; $display("FAIL release_ready1 got=%b exp=1", in_ready1); end
    tests++; if (in_ready0 !== 1'b1) begin fails++; $display("FAIL release_ready0 got=%b exp=1", in_ready0); end
    @(negedge clk);
  endtask

  task automatic test_streaming();
    logic [DW-1:0] e;
    idle();
    for (int i = 0; i < 8; i++) begin
      e = 64'hA1 + 64'(i);
      in_valid1 = 1'b1; in_data1 = e; in_flags1 = mkf(e);
      advance();
      tests++; if (acc1 !== 1'b1) begin fails++; $display("FAIL stream_accept beat=%0d got=%b exp=1", i, acc1); end
      tests++; if (out_valid1 !== 1'b1 || out_data1 !== e || out_flags1 !== mkf(e) || occupancy1 !== 2'd1) begin
        fails++; $display("FAIL stream_out beat=%0d got v=%b d=%h o=%0d exp v=1 d=%h o=1", i, out_valid1, out_data1, occupancy1, e);
      end
    end
    in_valid1 = 1'b0;
    advance();
    tests++; if (out_valid1 !== 1'b0 || out_flags1 !== '0 || occupancy1 !== 2'd0) begin
      fails++; $display("FAIL stream_drain got v=%b f=%h o=%0d exp 0", out_valid1, out_flags1, occupancy1);
    end
  endtask

  task automatic test_stall();
    idle();
    out_ready1 = 1'b0;
    in_valid1 = 1'b1; in_data1 = 64'hB1; in_flags1 = mkf(64'hB1);
    advance();
    tests++; if (occupancy1 !== 2'd1 || out_data1 !== 64'hB1) begin
      fails++; $display("FAIL stall_first got o=%0d d=%h exp o=1 d=b1", occupancy1, out_data1);
    end
    in_data1 = 64'hB2; in_flags1 = mkf(64'hB2);
    advance();
    in_valid1 = 1'b0;
    tests++; if (occupancy1 !== 2'd2 || in_ready1 !== 1'b0 || out_data1 !== 64'hB1) begin
      fails++; $display("FAIL stall_full got o=%0d r=%b d=%h exp o=2 r=0 d=b1", occupancy1, in_ready1, out_data1);
    end
    repeat (3) begin
      advance();
      tests++; if (out_valid1 !== 1'b1 || out_data1 !== 64'hB1 || out_flags1 !== mkf(64'hB1) || occupancy1 !== 2'd2) begin
        fails++; $display("FAIL stall_hold got v=%b d=%h o=%0d exp v=1 d=b1 o=2", out_valid1, out_data1, occupancy1);
      end
    end
    out_ready1 = 1'b1;
    advance();
    tests++; if (em1 !== 1'b1 || od1 !== 64'hB1) begin fails++; $display("FAIL stall_emit1 got em=%b d=%h exp em=1 d=b1", em1, od1); end
    tests++; if (out_data1 !== 64'hB2 || occupancy1 !== 2'd1) begin
      fails++; $display("FAIL stall_second got d=%h o=%0d exp d=b2 o=1", out_data1, occupancy1);
    end
    advance();
    tests++; if (out_valid1 !== 1'b0 || occupancy1 !== 2'd0) begin
      fails++; $display("FAIL stall_empty got v=%b o=%0d exp v=0 o=0", out_valid1, occupancy1);
    end
  endtask

  task automatic test_flush();
    idle();
    out_ready1 = 1'b0;
    in_valid1 = 1'b1; in_data1 = 64'hC1; in_flags1 = mkf(64'hC1);
    advance();
    in_data1 = 64'hC2; in_flags1 = mkf(64'hC2);
    advance();
    tests++; if (occupancy1 !== 2'd2) begin fails++; $display("FAIL flush_fill got o=%0d exp 2", occupancy1); end
    in_data1 = 64'hC3; in_flags1 = mkf(64'hC3); flush1 = 1'b1;
    advance();
    tests++; if (out_valid1 !== 1'b0 || occupancy1 !== 2'd0 || out_flags1 !== '0) begin
      fails++; $display("FAIL flush_clear got v=%b o=%0d f=%h exp 0", out_valid1, occupancy1, out_flags1);
    end
    flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1;
    repeat (3) begin
      advance();
      tests++; if (out_valid1 !== 1'b0 || out_flags1 !== '0) begin
        fails++; $display("FAIL flush_ghost got v=%b d=%h exp v=0", out_valid1, out_data1);
      end
    end
  endtask

  task automatic test_skid0();
    logic [DW-1:0] e;
    idle();
    out_ready0 = 1'b0;
    in_valid0 = 1'b1; in_data0 = 64'hD1; in_flags0 = mkf(64'hD1);
    advance();
    in_data0 = 64'hD2; in_flags0 = mkf(64'hD2);
    #1;
    tests++; if (occupancy0 !== 2'd1 || out_data0 !== 64'hD1 || in_ready0 !== 1'b0) begin
      fails++; $display("FAIL skid0_full got o=%0d d=%h r=%b exp o=1 d=d1 r=0", occupancy0, out_data0, in_ready0);
    end
    advance();
    tests++; if (out_data0 !== 64'hD1 || occupancy0 !== 2'd1) begin
      fails++; $display("FAIL skid0_nooverwrite got d=%h o=%0d exp d=d1 o=1", out_data0, occupancy0);
    end
    out_ready0 = 1'b1;
    #1;
    tests++; if (in_ready0 !== 1'b1) begin fails++; $display("FAIL skid0_ready_comb got=%b exp=1", in_ready0); end
    for (int k = 2; k <= 5; k++) begin
      e = 64'hD0 + 64'(k);
      in_data0 = e; in_flags0 = mkf(e);
      advance();
      tests++; if (acc0 !== 1'b1 || out_data0 !== e || out_flags0 !== mkf(e) || occupancy0 !== 2'd1) begin
        fails++; $display("FAIL skid0_replace k=%0d got a=%b d=%h o=%0d exp a=1 d=%h o=1", k, acc0, out_data0, occupancy0, e);
      end
    end
    in_valid0 = 1'b0;
    advance();
    tests++; if (out_valid0 !== 1'b0 || occupancy0 !== 2'd0) begin
      fails++; $display("FAIL skid0_drain got v=%b o=%0d exp 0", out_valid0, occupancy0);
    end
  endtask

  task automatic test_random();
    int acc_n1 = 0;
    int acc_n0 = 0;
    int cyc = 0;
    bit draining;
    logic pst1 = 1'b0;
    logic pst0 = 1'b0;
    logic [DW-1:0] pod1, pod0;
    logic [FC-1:0] pof1, pof0;
    logic [DW+FC-1:0] e;
    idle();
    while (cyc < 60000) begin
      draining = (acc_n1 >= 10000) && (acc_n0 >= 10000);
      if (draining && q1.size() == 0 && q0.size() == 0) break;
      if (draining) begin
        idle();
      end else begin
        in_valid1 = ($urandom_range(0, 3) != 0); out_ready1 = ($urandom_range(0, 3) != 0);
        flush1 = ($urandom_range(0, 299) == 0);
        in_data1 = {$urandom, $urandom}; in_flags1 = mkf(in_data1);
        in_valid0 = ($urandom_range(0, 3) != 0); out_ready0 = ($urandom_range(0, 3) != 0);
        flush0 = ($urandom_range(0, 299) == 0);
        in_data0 = {$urandom, $urandom}; in_flags0 = mkf(in_data0);
      end
      advance();
      cyc++;
      tests++; if (!v1 && of1 !== '0) begin fails++; $display("FAIL rand1_bubble got f=%h exp 0", of1); end
      tests++; if (oc1 !== 2'(q1.size()) || ir1 !== (q1.size() != 2)) begin
        fails++; $display("FAIL rand1_occ got o=%0d r=%b exp o=%0d", oc1, ir1, q1.size());
      end
      if (pst1) begin
        tests++; if (v1 !== 1'b1 || od1 !== pod1 || of1 !== pof1) begin
          fails++; $display("FAIL rand1_stall got d=%h exp d=%h", od1, pod1);
        end
      end
      if (em1) begin
        tests++;
        if (q1.size() == 0) begin fails++; $display("FAIL rand1_dup got d=%h exp none", od1); end
        else begin
          e = q1.pop_front();
          if ({of1, od1} !== e) begin fails++; $display("FAIL rand1_order got %h exp %h", {of1, od1}, e); end
        end
      end
      if (fl1) q1.delete();
      else if (acc1) begin q1.push_back({if1, id1}); acc_n1++; end
      pst1 = v1 && !or1 && !fl1; pod1 = od1; pof1 = of1;

      tests++; if (!v0 && of0 !== '0) begin fails++; $display("FAIL rand0_bubble got f=%h exp 0", of0); end
      tests++; if (oc0 !== 2'(q0.size()) || ir0 !== ((q0.size() == 0) || or0)) begin
        fails++; $display("FAIL rand0_occ got o=%0d r=%b exp o=%0d", oc0, ir0, q0.size());
      end
      if (pst0) begin
        tests++; if (v0 !== 1'b1 || od0 !== pod0 || of0 !== pof0) begin
          fails++; $display("FAIL rand0_stall got d=%h exp d=%h", od0, pod0);
        end
      end
      if (em0) begin
        tests++;
        if (q0.size() == 0) begin fails++; $display("FAIL rand0_dup got d=%h exp none", od0); end
        else begin
          e = q0.pop_front();
          if ({of0, od0} !== e) begin fails++; $display("FAIL rand0_order got %h exp %h", {of0, od0}, e); end
        end
      end
      if (fl0) q0.delete();
      else if (acc0) begin q0.push_back({if0, id0}); acc_n0++; end
      pst0 = v0 && !or0 && !fl0; pod0 = od0; pof0 = of0;
    end
    tests++; if (cyc >= 60000) begin fails++; $display("FAIL rand_timeout got cyc=%0d exp <60000", cyc); end
    tests++; if (q1.size() != 0 || q0.size() != 0 || out_valid1 !== 1'b0 || out_valid0 !== 1'b0) begin
      fails++; $display("FAIL rand_leftover got q1=%0d q0=%0d exp 0", q1.size(), q0.size());
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_skid0();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
